// File: rtl/servo_pwm_array.sv
// -----------------------------------------------------------------------------
// servo_pwm_array
//   Multi-channel servo PWM generator. One shared tick prescaler and frame
//   counter drive NUM_CH independent pulse outputs. New positions land in
//   per-channel shadow registers (clamped to MAX_POS) and are transferred to
//   the active registers only at the frame boundary, so a pulse in flight is
//   never reshaped. The output enable is also sampled only at the boundary.
//
//   Optional build macro: SERVO_SLEW_EN
//     defined   - at each boundary active moves toward shadow by at most
//                 SLEW_STEP, landing exactly on shadow.
//     undefined - active takes shadow directly; no slew logic is built.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   enable       output enable request, sampled at frame boundary
//   pos_data     packed positions, channel i at [i*POS_W +: POS_W]
//   pos_valid    per-channel one-clk load strobe
//   pwm_out      registered servo pulse outputs
//   frame_start  one-clk pulse at the start of every frame
//   pos_clamped  one-clk pulse when a written position exceeded MAX_POS
// -----------------------------------------------------------------------------
module servo_pwm_array #(
  parameter int NUM_CH      = 2,
  parameter int POS_W       = 10,
  parameter int TICK_DIV    = 50,
  parameter int FRAME_TICKS = 4000,
  parameter int MIN_TICKS   = 200,
  parameter int MAX_POS     = 1023,
  parameter int CENTER_POS  = 512,
  parameter int SLEW_STEP   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [NUM_CH*POS_W-1:0] pos_data,
  input  logic [NUM_CH-1:0]       pos_valid,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic                    frame_start,
  output logic [NUM_CH-1:0]       pos_clamped
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int FC_W  = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [FC_W-1:0]  FC_LAST   = FC_W'(FRAME_TICKS - 1);
  localparam logic [FC_W-1:0]  MIN_V     = FC_W'(MIN_TICKS);
  localparam logic [POS_W-1:0] MAX_POS_V = POS_W'(MAX_POS);
  localparam logic [POS_W-1:0] CENTER_V  = POS_W'(CENTER_POS);

  // Parameter sanity: the longest pulse must fit inside one frame.
  generate
    if (MIN_TICKS + MAX_POS >= FRAME_TICKS) begin : g_err_range
      $error("servo_pwm_array: MIN_TICKS + MAX_POS must be < FRAME_TICKS");
    end
    if (CENTER_POS > MAX_POS) begin : g_err_center
      $error("servo_pwm_array: CENTER_POS must be <= MAX_POS");
    end
    if (TICK_DIV < 1) begin : g_err_div
      $error("servo_pwm_array: TICK_DIV must be >= 1");
    end
    if (SLEW_STEP < 1) begin : g_err_slew
      $error("servo_pwm_array: SLEW_STEP must be >= 1");
    end
  endgenerate

`ifdef SERVO_SLEW_EN
  // A step larger than the whole range behaves like a direct load.
  localparam int               STEP_EFF = (SLEW_STEP > MAX_POS) ? MAX_POS : SLEW_STEP;
  localparam logic [POS_W-1:0] STEP_V   = POS_W'(STEP_EFF);
`endif

  // ---------------------------------------------------------------------------
  // Shared timebase
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt;
  logic [FC_W-1:0]  frame_cnt;
  logic             en_active;
  logic             tick;
  logic             boundary;

  assign tick     = (div_cnt == DIV_LAST);
  assign boundary = tick && (frame_cnt == FC_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      frame_cnt   <= '0;
      en_active   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) begin
        frame_cnt <= (frame_cnt == FC_LAST) ? '0 : frame_cnt + 1'b1;
      end
      if (boundary) begin
        en_active <= enable;
      end
      // First clk of frame_cnt==0 is the only one with div_cnt==0, so this
      // is a single-clk pulse aligned with the first high clk of pwm_out.
      frame_start <= (frame_cnt == '0) && (div_cnt == '0);
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel shadow/active registers and pulse comparator
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [POS_W-1:0] pos_in;
      logic             over;
      logic [POS_W-1:0] shadow;
      logic [POS_W-1:0] active;
      logic [POS_W-1:0] active_next;
      logic [FC_W-1:0]  width;
      logic             pwm_q;
      logic             clamp_q;

      assign pos_in = pos_data[gi*POS_W +: POS_W];
      assign over   = (pos_in > MAX_POS_V);
      // MIN_TICKS + MAX_POS < FRAME_TICKS, so this sum cannot overflow FC_W.
      assign width  = MIN_V + FC_W'(active);

`ifdef SERVO_SLEW_EN
      // Moving toward shadow (which is already within 0..MAX_POS) never
      // passes it, so the step saturates at 0 and MAX_POS by construction.
      logic [POS_W-1:0] diff;
      always_comb begin
        diff        = '0;
        active_next = active;
        if (shadow > active) begin
          diff        = shadow - active;
          active_next = (diff > STEP_V) ? active + STEP_V : shadow;
        end else if (shadow < active) begin
          diff        = active - shadow;
          active_next = (diff > STEP_V) ? active - STEP_V : shadow;
        end
      end
`else
      assign active_next = shadow;
`endif

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          shadow  <= CENTER_V;
          active  <= CENTER_V;
          pwm_q   <= 1'b0;
          clamp_q <= 1'b0;
        end else begin
          clamp_q <= pos_valid[gi] && over;
          if (pos_valid[gi]) begin
            shadow <= over ? MAX_POS_V : pos_in;
          end
          // On a boundary write, active sees the old shadow (non-blocking).
          if (boundary) begin
            active <= active_next;
          end
          pwm_q <= en_active && (frame_cnt < width);
        end
      end

      assign pwm_out[gi]     = pwm_q;
      assign pos_clamped[gi] = clamp_q;
    end
  endgenerate

endmodule

// File: tb/tb_servo_pwm_array.sv
// -----------------------------------------------------------------------------
// tb_servo_pwm_array
//   Scoreboard bench for servo_pwm_array. Each test pushes the expected
//   per-frame pulse widths (in clk) as it drives stimulus; a monitor measures
//   every completed frame between frame_start pulses and pops/compares.
// -----------------------------------------------------------------------------
module tb_servo_pwm_array;

  localparam int NUM_CH      = 2;
  localparam int POS_W       = 4;
  localparam int TICK_DIV    = 2;
  localparam int FRAME_TICKS = 32;
  localparam int MIN_TICKS   = 4;
  localparam int MAX_POS     = 12;
  localparam int CENTER_POS  = 6;
  localparam int SLEW_STEP   = 2;
  localparam int FRAME_CLK   = FRAME_TICKS * TICK_DIV;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    enable = 1'b0;
  logic [NUM_CH*POS_W-1:0] pos_data = '0;
  logic [NUM_CH-1:0]       pos_valid = '0;
  logic [NUM_CH-1:0]       pwm_out;
  logic                    frame_start;
  logic [NUM_CH-1:0]       pos_clamped;

  servo_pwm_array #(
    .NUM_CH(NUM_CH), .POS_W(POS_W), .TICK_DIV(TICK_DIV),
    .FRAME_TICKS(FRAME_TICKS), .MIN_TICKS(MIN_TICKS), .MAX_POS(MAX_POS),
    .CENTER_POS(CENTER_POS), .SLEW_STEP(SLEW_STEP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pos_data(pos_data),
    .pos_valid(pos_valid), .pwm_out(pwm_out), .frame_start(frame_start),
    .pos_clamped(pos_clamped)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int w0;
    int w1;
  } frame_exp_t;

  frame_exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model of the boundary behaviour
  int m_act[2];
  int m_shd[2];
  bit m_en;

  function automatic int step_to(int a, int s);
`ifdef SERVO_SLEW_EN
    if (s > a + SLEW_STEP) return a + SLEW_STEP;
    if (s < a - SLEW_STEP) return a - SLEW_STEP;
    return s;
`else
    return s;
`endif
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < 2; c++) begin
      m_act[c] = CENTER_POS;
      m_shd[c] = CENTER_POS;
    end
    m_en = 1'b0;
  endfunction

  function automatic void model_write(int ch, int v);
    m_shd[ch] = (v > MAX_POS) ? MAX_POS : v;
  endfunction

  function automatic void advance(bit en);
    for (int c = 0; c < 2; c++) m_act[c] = step_to(m_act[c], m_shd[c]);
    m_en = en;
  endfunction

  function automatic void push_frame();
    frame_exp_t e;
    e.w0 = m_en ? (MIN_TICKS + m_act[0]) * TICK_DIV : 0;
    e.w1 = m_en ? (MIN_TICKS + m_act[1]) * TICK_DIV : 0;
    sb.push_back(e);
  endfunction

  // Monitor: measures each frame and compares against the scoreboard.
  initial begin : monitor
    int period;
    int cnt0;
    int cnt1;
    bit started;
    frame_exp_t e;
    period = 0; cnt0 = 0; cnt1 = 0; started = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        started = 1'b0;
      end else begin
        if (frame_start) begin
          if (started) begin
            n_checks++;
            if (period !== FRAME_CLK) begin
              n_fail++;
              $display("FAIL frame_period: got %0d clk, expected %0d clk", period, FRAME_CLK);
            end
            if (sb.size() > 0) begin
              e = sb.pop_front();
              $display("frame @%0t: ch0 %0d clk (exp %0d), ch1 %0d clk (exp %0d)",
                       $time, cnt0, e.w0, cnt1, e.w1);
              n_checks++;
              if (cnt0 !== e.w0) begin
                n_fail++;
                $display("FAIL ch0_width: got %0d clk, expected %0d clk", cnt0, e.w0);
              end
              n_checks++;
              if (cnt1 !== e.w1) begin
                n_fail++;
                $display("FAIL ch1_width: got %0d clk, expected %0d clk", cnt1, e.w1);
              end
            end
          end
          started = 1'b1;
          period = 0; cnt0 = 0; cnt1 = 0;
        end
        period++;
        if (pwm_out[0] === 1'b1) cnt0++;
        if (pwm_out[1] === 1'b1) cnt1++;
      end
    end
  end

  // Wait for the next frame_start (bounded), return 1 clk + 1 ns after it.
  task automatic wait_fs();
    int budget;
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (!frame_start && budget < 3 * FRAME_CLK);
    n_checks++;
    if (frame_start !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_start_timeout: no frame_start within %0d clk", budget);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; pos_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (pwm_out !== 2'b00) begin n_fail++; $display("FAIL reset_pwm: got %b, expected 00", pwm_out); end
    n_checks++;
    if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_frame_start: got %b, expected 0", frame_start); end
    n_checks++;
    if (pos_clamped !== 2'b00) begin n_fail++; $display("FAIL reset_clamped: got %b, expected 00", pos_clamped); end
    $display("reset: pwm_out=%b frame_start=%b pos_clamped=%b", pwm_out, frame_start, pos_clamped);
    @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b1;
    model_reset();
    wait_fs();
  endtask

  task automatic test_basic();
    push_frame();
    advance(1'b1); push_frame();
    advance(1'b1); push_frame();
    repeat (3) wait_fs();
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL basic_drain: %0d left, expected 0", sb.size()); end
    advance(1'b1);
  endtask

  task automatic test_load();
    push_frame();
    @(negedge clk);
    repeat (9) @(negedge clk);
    pos_data = {4'd0, 4'd10}; pos_valid = 2'b01; model_write(0, 10);
    @(negedge clk);
    pos_valid = 2'b00;
    $display("write ch0=10: pos_clamped=%b", pos_clamped);
    n_checks++;
    if (pos_clamped !== 2'b00) begin n_fail++; $display("FAIL load_clamped: got %b, expected 00", pos_clamped); end
    advance(1'b1); push_frame();
    repeat (2) wait_fs();
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL load_drain: %0d left, expected 0", sb.size()); end
    advance(1'b1);
  endtask

  task automatic test_clamp();
    push_frame();
    @(negedge clk);
    repeat (9) @(negedge clk);
    pos_data = {4'd15, 4'd0}; pos_valid = 2'b10; model_write(1, 15);
    @(negedge clk);
    pos_valid = 2'b00;
    $display("write ch1=15: pos_clamped=%b", pos_clamped);
    n_checks++;
    if (pos_clamped !== 2'b10) begin n_fail++; $display("FAIL clamp_pulse: got %b, expected 10", pos_clamped); end
    @(negedge clk);
    n_checks++;
    if (pos_clamped !== 2'b00) begin n_fail++; $display("FAIL clamp_one_clk: got %b, expected 00", pos_clamped); end
    advance(1'b1); push_frame();
    repeat (2) wait_fs();
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL clamp_drain: %0d left, expected 0", sb.size()); end
    advance(1'b1);
  endtask

  task automatic test_boundary_write();
    push_frame();
    @(negedge clk);
    repeat (61) @(negedge clk);
    // Strobe captured by the boundary edge itself.
    pos_data = {4'd0, 4'd2}; pos_valid = 2'b01;
    @(negedge clk);
    pos_valid = 2'b00;
    $display("write ch0=2 on boundary cycle");
    advance(1'b1); model_write(0, 2); push_frame();
    advance(1'b1); push_frame();
    repeat (3) wait_fs();
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL boundary_drain: %0d left, expected 0", sb.size()); end
    advance(1'b1);
  endtask

  task automatic test_enable();
    push_frame();
    @(negedge clk);
    repeat (4) @(negedge clk);
    enable = 1'b0;
    $display("enable=0 mid-pulse: pwm_out=%b", pwm_out);
    advance(1'b0); push_frame();
    advance(1'b0); push_frame();
    repeat (2) wait_fs();
    repeat (20) @(negedge clk);
    n_checks++;
    if (pwm_out !== 2'b00) begin n_fail++; $display("FAIL disabled_low: got %b, expected 00", pwm_out); end
    enable = 1'b1;
    $display("enable=1 mid-frame");
    advance(1'b1); push_frame();
    repeat (2) wait_fs();
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL enable_drain: %0d left, expected 0", sb.size()); end
    advance(1'b1);
  endtask

  task automatic test_back_to_back();
    push_frame();
    @(negedge clk);
    repeat (2) @(negedge clk);
    pos_data = {4'd3, 4'd5}; pos_valid = 2'b11; model_write(0, 5); model_write(1, 3);
    @(negedge clk);
    pos_data = {4'd9, 4'd0}; pos_valid = 2'b10; model_write(1, 9);
    @(negedge clk);
    pos_valid = 2'b00;
    $display("writes ch0=5 ch1=3 then ch1=9: pos_clamped=%b", pos_clamped);
    n_checks++;
    if (pos_clamped !== 2'b00) begin n_fail++; $display("FAIL b2b_clamped: got %b, expected 00", pos_clamped); end
    advance(1'b1); push_frame();
    repeat (2) wait_fs();
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL b2b_drain: %0d left, expected 0", sb.size()); end
    advance(1'b1);
  endtask

  task automatic test_reset_mid_pulse();
    logic [1:0] exp_pwm;
    @(negedge clk);
    repeat (4) @(negedge clk);
    exp_pwm = m_en ? 2'b11 : 2'b00;
    n_checks++;
    if (pwm_out !== exp_pwm) begin n_fail++; $display("FAIL pre_reset_pwm: got %b, expected %b", pwm_out, exp_pwm); end
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset mid-pulse: pwm_out=%b", pwm_out);
    n_checks++;
    if (pwm_out !== 2'b00) begin n_fail++; $display("FAIL async_reset_pwm: got %b, expected 00", pwm_out); end
    n_checks++;
    if (frame_start !== 1'b0) begin n_fail++; $display("FAIL async_reset_fs: got %b, expected 0", frame_start); end
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_fs();
    push_frame();
    @(negedge clk);
    repeat (2) @(negedge clk);
    pos_data = {4'd0, 4'd12}; pos_valid = 2'b01; model_write(0, 12);
    @(negedge clk);
    pos_valid = 2'b00;
    $display("write ch0=12 after reset");
    advance(1'b1); push_frame();
    advance(1'b1); push_frame();
    advance(1'b1); push_frame();
    repeat (4) wait_fs();
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL post_reset_drain: %0d left, expected 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_load();
    test_clamp();
    test_boundary_write();
    test_enable();
    test_back_to_back();
    test_reset_mid_pulse();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/servo_pwm_array.md
Name: servo_pwm_array

Overview:
- Multi-channel, parametrised servo PWM generator. Replaces the single-channel driver in the UART servo controller path.
- One shared tick prescaler and frame counter drive NUM_CH independent pulse outputs.
- Positions written by the UART command decoder go to per-channel shadow registers. They are applied glitch-free at frame boundaries, with range clamping and frame-aligned enable.

Parameters:
- NUM_CH, 2, number of servo channels
- POS_W, 10, position word width (unsigned)
- TICK_DIV, 50, clk cycles per PWM tick (>=1)
- FRAME_TICKS, 4000, ticks per frame
- MIN_TICKS, 200, pulse width in ticks at position 0
- MAX_POS, 1023, largest accepted position; larger values are clamped
- CENTER_POS, 512, position loaded on reset
- SLEW_STEP, 8, max position change per frame (used only with SERVO_SLEW_EN)

Ports:
- clk, input, 1, system clock
- rst_n, input, 1, asynchronous active-low reset
- enable, input, 1, request outputs active; sampled at frame boundary only
- pos_data, input, NUM_CH*POS_W, packed positions; channel i at bits [i*POS_W +: POS_W]
- pos_valid, input, NUM_CH, per-channel load strobe, one clk each
- pwm_out, output, NUM_CH, servo pulse outputs (registered)
- frame_start, output, 1, one-clk pulse marking frame start
- pos_clamped, output, NUM_CH, one-clk pulse when a written value was clamped

Behaviour:
- Reset (async, rst_n=0):
  - pwm_out=0, frame_start=0, pos_clamped=0 immediately.
  - Prescaler=0, frame_cnt=0, en_active=0.
  - shadow_i=active_i=CENTER_POS.
- Prescaler: div_cnt counts 0..TICK_DIV-1. tick=1 when div_cnt==TICK_DIV-1.
- Frame counter:
  - frame_cnt increments on tick and wraps FRAME_TICKS-1 -> 0.
  - Boundary = tick while frame_cnt==FRAME_TICKS-1.
- Counter widths: $clog2 of range. Elaboration error if MIN_TICKS+MAX_POS >= FRAME_TICKS or CENTER_POS > MAX_POS.
- Load: pos_valid[i]=1 -> shadow_i <= min(pos_data_i, MAX_POS) next clk.
  - pos_clamped[i] pulses on the same edge if pos_data_i > MAX_POS.
  - Multiple writes within one frame: the last write wins.
- Boundary edge:
  - active_i <= shadow_i for all channels.
  - en_active <= enable.
- Write on the boundary cycle: shadow_i captures the new value. active_i takes the old shadow_i. The new value applies one frame later.
- width_i = MIN_TICKS + active_i, computed at width of frame_cnt.
- pwm_out_i <= en_active & (frame_cnt < width_i), registered every clk. Latency: 1 clk after frame_cnt change.
- Pulse length in clk = width_i*TICK_DIV. Frame period = FRAME_TICKS*TICK_DIV clk.
- frame_start: registered, high for one clk after frame_cnt becomes 0. Coincides with the first high clk of pwm_out when en_active=1.
- Disabling mid-frame never truncates a pulse. Outputs stay low until the boundary after enable returns.
- Reset mid-pulse: outputs drop asynchronously. After release, the first frame is low because en_active=0.
- Channels are fully independent. No ordering between pos_valid bits.

Optional Feature:
- Macro: SERVO_SLEW_EN
- Defined: at each boundary, active_i moves toward shadow_i by at most SLEW_STEP per frame. It reaches shadow_i exactly, with no overshoot. Arithmetic is saturating at 0 and MAX_POS.
- Undefined: active_i <= shadow_i directly. SLEW_STEP is ignored and no slew logic is synthesised.

Test Plan:
Bench params: NUM_CH=2, POS_W=4, TICK_DIV=2, FRAME_TICKS=32, MIN_TICKS=4, MAX_POS=12, CENTER_POS=6, SLEW_STEP=2.
1. Release reset, enable=1 -> frame 1: pwm_out=00. From frame 2: each channel high 20 clk of every 64 clk; frame_start every 64 clk.
2. Mid-frame, pos_valid=01, ch0=10 -> current frame ch0 stays 20 clk, next frame 28 clk; ch1 stays 20 clk.
3. ch1=15 -> pos_clamped=10 for one clk; ch1 pulse 32 clk from next frame.
4. ch0=2 on the boundary cycle -> next frame uses the prior shadow; the frame after gives 12 clk.
5. enable=0 at clk 5 of a pulse -> pulse completes at full width; following frames low. Re-enable -> pulses resume after the next boundary.
6. rst_n low mid-pulse -> pwm_out=00 same cycle (async). With SERVO_SLEW_EN, ch0 6->12 gives widths 24, 28, 32 clk over three frames.
